// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Each bit is held for CLK_DIV clock cycles.
// One word is accepted per valid/ready handshake, and only while idle.
module uart_tx_param #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 ret,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BAUD_W = $clog2(CLK_DIV);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    generate
        if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    logic [2:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 bit_end;

    // Handshake and status flags follow the state directly.
    always_comb begin
        ready   = (state == IDLE);
        busy    = (state != IDLE);
        bit_end = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    end

    // Frame sequencer: baud/bit counters, shift register and registered tx.
    // tx is loaded with the value of the next bit at each bit boundary so the
    // line changes exactly on the boundary edge and never glitches.
    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
                tx       <= 1'b1;
                if (valid) begin
                    state     <= START;
                    shift_reg <= data;
                    par_bit   <= (^data) ^ 1'(PARITY_ODD);
                    tx        <= 1'b0;
                end
            end else if (!bit_end) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                    STOP: begin
                        tx <= 1'b1;
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state      <= IDLE;
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: three instances with different frame formats
// (CLK_DIV=4 throughout), checked cycle by cycle against hand-built frames.
module tb_uart_tx_param;

    logic       clk;
    logic       ret;
    logic [7:0] data_bus;
    logic [2:0] valid_v;
    logic [2:0] ready_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int n_checks;
    int n_pass;

    // 0: 8 data, even parity, 1 stop
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .ret(ret), .data(data_bus), .valid(valid_v[0]), .ready(ready_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

    // 1: 8 data, odd parity, 2 stops
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .ret(ret), .data(data_bus), .valid(valid_v[1]), .ready(ready_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

    // 2: 7 data, no parity, 1 stop
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_c (
        .clk(clk), .ret(ret), .data(data_bus[6:0]), .valid(valid_v[2]), .ready(ready_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid on one instance and let the next edge accept the word.
    task automatic start_frame(input int which, input logic [7:0] d);
        check($sformatf("ready before accept %0d", which), ready_v[which], 1'b1);
        data_bus       = d;
        valid_v[which] = 1'b1;
        tick();
    endtask

    // Called one cycle after the accepting edge. Checks tx against the frame
    // bit for every cycle (4 cycles per bit), then the first IDLE cycle.
    // mode 0: valid low; mode 1: valid held, data changed to nxt mid-frame;
    // mode 2: data and valid scrambled every cycle.
    task automatic check_frame(input int which, input string tag, input logic [15:0] frame,
                               input int nbits, input int mode, input logic [7:0] nxt);
        for (int c = 0; c < nbits * 4; c++) begin
            check($sformatf("%s tx c%0d", tag, c), tx_v[which], frame[c / 4]);
            check($sformatf("%s ready c%0d", tag, c), ready_v[which], 1'b0);
            check($sformatf("%s busy c%0d", tag, c), busy_v[which], 1'b1);
            case (mode)
                0: valid_v[which] = 1'b0;
                1: if (c == 0) data_bus = nxt;
                default: begin
                    data_bus       = 8'($urandom);
                    valid_v[which] = (c == nbits * 4 - 1) ? 1'b0 : 1'($urandom_range(0, 1));
                end
            endcase
            tick();
        end
        check({tag, " done"}, done_v[which], 1'b1);
        check({tag, " ready end"}, ready_v[which], 1'b1);
        check({tag, " busy end"}, busy_v[which], 1'b0);
        check({tag, " tx end"}, tx_v[which], 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        data_bus = 8'h00;
        valid_v  = 3'b000;
        ret      = 1'b1;
        #1 ret   = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst tx %0d", i), tx_v[i], 1'b1);
            check($sformatf("rst ready %0d", i), ready_v[i], 1'b1);
            check($sformatf("rst busy %0d", i), busy_v[i], 1'b0);
            check($sformatf("rst done %0d", i), done_v[i], 1'b0);
        end
        valid_v = 3'b111;
        tick();
        tick();
        valid_v = 3'b000;
        ret = 1'b1;
        tick();
        check("post-reset idle busy", busy_v[0], 1'b0);

        // 0x75, even parity bit 1, one stop: 44 cycles
        start_frame(0, 8'h75);
        check_frame(0, "a75", {1'b1, 1'b1, 8'h75, 1'b0}, 11, 0, 8'h00);
        tick();
        check("a75 done pulse width", done_v[0], 1'b0);

        // 0x75, odd parity bit 0, two stops: 48 cycles
        start_frame(1, 8'h75);
        check_frame(1, "b75", {2'b11, 1'b0, 8'h75, 1'b0}, 12, 0, 8'h00);
        tick();
        check("b75 done pulse width", done_v[1], 1'b0);

        // 7 data bits, no parity: 36 cycles
        start_frame(2, 8'h00);
        check_frame(2, "c00", {1'b1, 7'h00, 1'b0}, 9, 0, 8'h00);
        tick();
        start_frame(2, 8'h5A);
        check_frame(2, "c5a", {1'b1, 7'h5A, 1'b0}, 9, 0, 8'h00);
        tick();

        // back-to-back: valid held, second start one cycle after frame_done
        start_frame(0, 8'hA5);
        check_frame(0, "bb1", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1, 8'h3C);
        tick();
        check_frame(0, "bb2", {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 0, 8'h00);
        tick();

        // handshake stress: word latched at acceptance survives scrambling
        start_frame(0, 8'h3C);
        check_frame(0, "stress", {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 2, 8'h00);
        valid_v[0] = 1'b0;
        tick();

        // reset mid-frame: 10 cycles in, tx is data bit 1 of 0x75 (0)
        start_frame(0, 8'h75);
        valid_v[0] = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("mid tx before reset", tx_v[0], 1'b0);
        ret = 1'b0;
        #1;
        check("mid rst tx", tx_v[0], 1'b1);
        check("mid rst ready", ready_v[0], 1'b1);
        check("mid rst busy", busy_v[0], 1'b0);
        check("mid rst done", done_v[0], 1'b0);
        valid_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("in rst tx c%0d", c), tx_v[0], 1'b1);
            check($sformatf("in rst done c%0d", c), done_v[0], 1'b0);
        end
        valid_v[0] = 1'b0;
        ret = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            check($sformatf("after rst done c%0d", c), done_v[0], 1'b0);
            check($sformatf("after rst tx c%0d", c), tx_v[0], 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
